// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, word width, NOP and reset PC defaults,
// and the IF/ID payload type.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction word used for flushed or empty IF/ID slots.
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    // Default first fetch address after reset.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

    // Payload carried by the IF/ID register and the skid buffer.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] npc;
    } ifid_entry_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, npc} skid buffer. Holds a fetch response that returned while the pipeline
// was stalled. Clear wins over load, load wins over drain.
module if_skid_buf
    import pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  ifid_entry_t entry_i,
    output ifid_entry_t entry_o,
    output logic        full_o
);

    ifid_entry_t entry_q, entry_d;
    logic        full_q, full_d;

    // Next-state for the buffer contents and occupancy.
    always_comb begin
        entry_d = entry_q;
        full_d  = full_q;
        if (clear_i) begin
            entry_d = '0;
            full_d  = 1'b0;
        end else if (load_i) begin
            entry_d = entry_i;
            full_d  = 1'b1;
        end else if (drain_i) begin
            full_d  = 1'b0;
        end
    end

    // Buffer registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
            full_q  <= 1'b0;
        end else begin
            entry_q <= entry_d;
            full_q  <= full_d;
        end
    end

    assign entry_o = entry_q;
    assign full_o  = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, request/acknowledge instruction-memory port, IF/ID register with
// a one-entry skid buffer, and redirect handling that drops an in-flight wrong-path fetch.
// Optional feature macro IF_PERF_EN adds perf_fetched / perf_bubble counters.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ID_Instr,
    output logic [XLEN-1:0] ID_NPC,
    output logic            ID_Valid
`ifdef IF_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_bubble
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;

    ifid_entry_t     ifid_q, ifid_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic            ifid_load;

    logic            skid_load, skid_drain, skid_clear, skid_full;
    ifid_entry_t     skid_in, skid_out;
    ifid_entry_t     bubble;
    logic [XLEN-1:0] pc_next_seq;

    assign bubble      = '{instr: NOP_INSTR, npc: '0};
    assign pc_next_seq = pc_step(pc_q);
    assign skid_in     = '{instr: imem_rdata, npc: pc_next_seq};

    if_skid_buf u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .entry_i (skid_in),
        .entry_o (skid_out),
        .full_o  (skid_full)
    );

    // Fetch FSM next-state, PC update, IF/ID load decision and skid control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_load    = 1'b0;
        ifid_d       = ifid_q;
        ifid_valid_d = ifid_valid_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                state_d = StReq;
            end

            StReq: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    ifid_load    = 1'b1;
                    ifid_d       = bubble;
                    ifid_valid_d = 1'b0;
                    skid_clear   = 1'b1;
                    // Without an ack the old request is still owed a response.
                    state_d      = imem_ack ? StReq : StDrop;
                end else if (imem_ack && !stall) begin
                    ifid_load    = 1'b1;
                    ifid_d       = '{instr: imem_rdata, npc: pc_next_seq};
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_next_seq;
                end else if (imem_ack) begin
                    skid_load = 1'b1;
                    pc_d      = pc_next_seq;
                    state_d   = StHold;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_d       = bubble;
                    ifid_valid_d = 1'b0;
                end
            end

            StHold: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    ifid_load    = 1'b1;
                    ifid_d       = bubble;
                    ifid_valid_d = 1'b0;
                    skid_clear   = 1'b1;
                    state_d      = StReq;
                end else if (!stall && skid_full) begin
                    ifid_load    = 1'b1;
                    ifid_d       = skid_out;
                    ifid_valid_d = 1'b1;
                    skid_drain   = 1'b1;
                    state_d      = StReq;
                end
            end

            StDrop: begin
                if (redirect) begin
                    pc_d         = redirect_pc;
                    ifid_load    = 1'b1;
                    ifid_d       = bubble;
                    ifid_valid_d = 1'b0;
                    state_d      = imem_ack ? StReq : StDrop;
                end else begin
                    if (!stall) begin
                        ifid_load    = 1'b1;
                        ifid_d       = bubble;
                        ifid_valid_d = 1'b0;
                    end
                    if (imem_ack) begin
                        state_d = StReq;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request is registered; a dropped request keeps its original address until acked.
    always_comb begin
        req_d  = (state_d == StReq) || (state_d == StDrop);
        addr_d = (state_d == StDrop) ? addr_q : pc_d;
    end

    // State, PC, memory port and IF/ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            ifid_q       <= '{instr: NOP_INSTR, npc: '0};
            ifid_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            if (ifid_load) begin
                ifid_q       <= ifid_d;
                ifid_valid_q <= ifid_valid_d;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ID_Instr  = ifid_q.instr;
    assign ID_NPC    = ifid_q.npc;
    assign ID_Valid  = ifid_valid_q;

`ifdef IF_PERF_EN
    logic [XLEN-1:0] perf_fetched_q, perf_bubble_q;

    // Count real-instruction loads and bubble/flush loads of IF/ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else if (ifid_load) begin
            if (ifid_valid_d) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_bubble_q  <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a transaction-level model plus directed scenarios.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ID_Instr;
    logic [31:0] ID_NPC;
    logic        ID_Valid;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
`endif

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ID_Instr    (ID_Instr),
        .ID_NPC      (ID_NPC),
        .ID_Valid    (ID_Valid)
`ifdef IF_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubble  (perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } ent_t;

    bit          m_started;
    bit          m_req;
    bit          m_drop;
    logic [31:0] m_pc, m_addr;
    logic [31:0] m_instr, m_npc;
    bit          m_valid;
    int unsigned m_fetched, m_bubble;
    ent_t        m_skid[$];

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_drop    = 1'b0;
        m_pc      = 32'h0;
        m_addr    = 32'h0;
        m_instr   = 32'h0;
        m_npc     = 32'h0;
        m_valid   = 1'b0;
        m_fetched = 0;
        m_bubble  = 0;
        m_skid.delete();
    endtask

    task automatic model_load(input logic [31:0] i, input logic [31:0] n, input bit v);
        m_instr = i;
        m_npc   = n;
        m_valid = v;
        if (v) m_fetched++;
        else   m_bubble++;
    endtask

    task automatic model_step();
        ent_t        e;
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (!m_started) begin
            if (redirect) m_pc = redirect_pc;
            m_started = 1'b1;
        end else if (redirect) begin
            m_pc = redirect_pc;
            model_load(32'h0, 32'h0, 1'b0);
            m_skid.delete();
            m_drop = m_req && !imem_ack;
        end else if (m_skid.size() != 0) begin
            if (!stall) begin
                model_load(m_skid[0].instr, m_skid[0].npc, 1'b1);
                void'(m_skid.pop_front());
            end
        end else if (m_drop) begin
            if (!stall) model_load(32'h0, 32'h0, 1'b0);
            if (imem_ack) m_drop = 1'b0;
        end else if (imem_ack) begin
            if (stall) begin
                e.instr = imem_rdata;
                e.npc   = seq;
                m_skid.push_back(e);
            end else begin
                model_load(imem_rdata, seq, 1'b1);
            end
            m_pc = seq;
        end else if (!stall) begin
            model_load(32'h0, 32'h0, 1'b0);
        end
        m_req = (m_skid.size() == 0);
        if (!m_drop) m_addr = m_pc;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Compare process: outputs are sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_req", {31'b0, imem_req}, {31'b0, m_req});
            if (m_req) chk("m_addr", imem_addr, m_addr);
            chk("m_instr", ID_Instr, m_instr);
            chk("m_npc", ID_NPC, m_npc);
            chk("m_valid", {31'b0, ID_Valid}, {31'b0, m_valid});
`ifdef IF_PERF_EN
            chk("m_perf_fetched", perf_fetched, m_fetched);
            chk("m_perf_bubble", perf_bubble, m_bubble);
`endif
        end
    end

    // ---------------- memory responder and stimulus ----------------
    bit mem_auto = 1'b1;
    int lat = 0;
    int cnt = 0;

    task automatic step();
        @(negedge clk);
        redirect = 1'b0;
        if (mem_auto) begin
            if (!imem_req) begin
                imem_ack = 1'b0;
                cnt = 0;
            end else if (cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr;
                cnt = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, ID_Instr, 32'h0);
        chk({tag, "_npc"}, ID_NPC, 32'h0);
        chk({tag, "_valid"}, {31'b0, ID_Valid}, 32'h0);
    endtask

    initial begin
        int          k;
        int          gap;
        logic [31:0] pat;
`ifdef IF_PERF_EN
        logic [31:0] pb0;
`endif
        // Reset state.
        repeat (3) step();
        chk_reset_vals("rst");
        rst = 1'b1;

        // Zero-wait memory, rdata = addr.
        step();
        chk("zw_first_req", {31'b0, imem_req}, 32'h1);
        chk("zw_first_addr", imem_addr, 32'h0);
        chk("zw_first_valid", {31'b0, ID_Valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("zw_instr", ID_Instr, 32'(4 * i));
            chk("zw_npc", ID_NPC, 32'(4 * i + 4));
            chk("zw_valid", {31'b0, ID_Valid}, 32'h1);
        end

        // Three-cycle ack latency: three bubbles between instructions.
        lat = 3;
        repeat (6) step();
        k = 0;
        while (ID_Valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("lat3_valid_seen", {31'b0, (k < 20)}, 32'h1);
`ifdef IF_PERF_EN
        pb0 = perf_bubble;
`endif
        gap = 0;
        step();
        while (ID_Valid !== 1'b1 && gap < 20) begin
            gap++;
            step();
        end
        chk("lat3_gap", 32'(gap), 32'd3);
`ifdef IF_PERF_EN
        chk("lat3_perf_bubble", perf_bubble - pb0, 32'd3);
`endif

        // Stall pattern against the model, one-cycle latency.
        lat = 1;
        pat = 32'b0110_1100_0011_1010_0111_0001_1011_0100;
        for (int i = 0; i < 32; i++) begin
            step();
            stall = pat[i];
        end
        stall = 1'b0;
        repeat (3) step();

        // Stall on the ack of 0x1234 at pc 0x10.
        mem_auto    = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        step();
        chk("drop_req", {31'b0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0000;
        step();
        chk("s3_addr", imem_addr, 32'h10);
        chk("s3_valid0", {31'b0, ID_Valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234;
        stall      = 1'b1;
        step();
        chk("s3_hold_req", {31'b0, imem_req}, 32'h0);
        chk("s3_hold_valid", {31'b0, ID_Valid}, 32'h0);
        imem_ack = 1'b0;
        step();
        chk("s3_hold_instr", ID_Instr, 32'h0);
        stall = 1'b0;
        step();
        chk("s3_instr", ID_Instr, 32'h1234);
        chk("s3_npc", ID_NPC, 32'h14);
        chk("s3_valid", {31'b0, ID_Valid}, 32'h1);
        chk("s3_next_addr", imem_addr, 32'h14);

        // Redirect with stall while the skid is full.
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA;
        stall      = 1'b1;
        step();
        chk("s5_hold_req", {31'b0, imem_req}, 32'h0);
        chk("s5_hold_instr", ID_Instr, 32'h1234);
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        chk("s5_addr", imem_addr, 32'h300);
        chk("s5_flush_valid", {31'b0, ID_Valid}, 32'h0);
        chk("s5_flush_instr", ID_Instr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBEEF;
        stall      = 1'b0;
        step();
        chk("s5_instr", ID_Instr, 32'hBEEF);
        chk("s5_npc", ID_NPC, 32'h304);

        // Redirect to 0x200 while the 0x40 request is outstanding.
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555;
        step();
        chk("s4_addr40", imem_addr, 32'h40);
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        chk("s4_drop_addr", imem_addr, 32'h40);
        chk("s4_drop_req", {31'b0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h4040;
        step();
        chk("s4_addr200", imem_addr, 32'h200);
        chk("s4_valid0", {31'b0, ID_Valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2000;
        step();
        chk("s4_instr", ID_Instr, 32'h2000);
        chk("s4_npc", ID_NPC, 32'h204);

        // Reset pulse in the middle of a dropped request.
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h500;
        step();
        chk("s6_drop_addr", imem_addr, 32'h204);
        #2 rst = 1'b0;
        #1 chk_reset_vals("arst");
        mem_auto = 1'b1;
        lat      = 0;
        cnt      = 0;
        imem_ack = 1'b0;
        #1 rst = 1'b1;
        step();
        chk("s6_restart_addr", imem_addr, 32'h0);
        chk("s6_restart_req", {31'b0, imem_req}, 32'h1);
        step();
        chk("s6_instr", ID_Instr, 32'h0);
        chk("s6_npc", ID_NPC, 32'h4);

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_instr", ID_Instr, 32'hFFFF_FFFC);
        chk("wrap_npc", ID_NPC, 32'h0);
        step();
        chk("wrap_next_npc", ID_NPC, 32'h4);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage feeding the ID stage, and through it the ID/EX pipeline register.
- Holds the PC and drives a request/acknowledge instruction-memory port that may take one or more cycles.
- Owns the IF/ID pipeline register, with a one-entry skid buffer to absorb responses that arrive while the pipeline is stalled.
- Accepts branch/jump redirects from EX, flushing wrong-path fetches, including one already in flight to memory.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on flush/bubble

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hazard-unit stall; hold IF/ID and PC
- redirect  in  1  one-cycle pulse from EX: taken branch/jump
- redirect_pc  in  32  target address, valid with redirect
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch address, stable while imem_req high
- imem_ack  in  1  response valid this cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- ID_Instr  out  32  IF/ID instruction
- ID_NPC  out  32  IF/ID PC+4
- ID_Valid  out  1  IF/ID holds a real instruction

## Operation
- FSM states: IDLE, REQ, HOLD, DROP.
  - Reset value: IDLE. IDLE→REQ on the first edge after reset release.
- REQ: imem_req=1, imem_addr=pc. On each edge:
  - redirect high: pc←redirect_pc; IF/ID←NOP_INSTR, Valid=0; skid cleared.
    - ack in the same cycle: data discarded, stay REQ.
    - no ack: →DROP.
  - else ack & !stall: IF/ID←{imem_rdata, pc+4, Valid=1}; pc←pc+4; stay REQ (back-to-back).
  - else ack & stall: skid←{imem_rdata, pc+4}; pc←pc+4; →HOLD.
  - else !ack & !stall: IF/ID←bubble (NOP_INSTR, Valid=0); stay REQ.
  - else (!ack & stall): IF/ID holds; stay REQ.
- HOLD: imem_req=0.
  - redirect: behaves as in REQ (flush, skid cleared), →REQ.
  - !stall: IF/ID←skid, Valid=1; skid emptied; →REQ.
- DROP: imem_req=1 with the old address; memory requires the request held until ack.
  - On ack: data discarded, →REQ with the new pc.
  - A further redirect in DROP: pc updated, stay DROP.
- Priority: rst > redirect > stall > ack.
- pc arithmetic: 32-bit, wraps modulo 2^32. ID_NPC = fetch address + 4, wrapping.
- While stall is high and no redirect: ID_Instr/ID_NPC/ID_Valid hold their values.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, ID_Instr=NOP_INSTR, ID_NPC=0, ID_Valid=0, pc=RESET_PC, skid empty, state IDLE.
- Reset asserted mid-transaction aborts it immediately; the memory must tolerate the abandoned request.
- First imem_req rises one edge after reset release.
- Zero-wait memory (ack in the request cycle): one instruction per cycle, IF/ID valid one edge after ack.
- Redirect cost: the IF/ID bubble is visible the edge after redirect; the target fetch is requested in the same cycle, or after the dropped ack.
- Stall at ack: the skid drains on the first edge with stall low; no instruction is lost or duplicated.

## Configuration
- IF_PERF_EN defined: adds outputs perf_fetched[31:0] and perf_bubble[31:0].
  - perf_fetched increments on each IF/ID load with Valid=1.
  - perf_bubble increments on each IF/ID bubble load.
  - Both reset to 0 and wrap at 2^32.
- IF_PERF_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - fetch FSM state encoding (IDLE, REQ, HOLD, DROP)
  - NOP constant
  - default RESET_PC
  - the 32-bit word width constant
- One sub-module: if_skid_buf, a one-entry {instr, npc} buffer with load/drain/clear and a full flag.

## Test plan
- Reset release, ack tied high, rdata=addr: ID_Instr sequence 0,4,8,…; ID_NPC 4,8,12,…; Valid=1 from cycle 3.
- Ack delayed 3 cycles per request: three bubbles (Valid=0) between instructions; perf_bubble=3 per fetch when IF_PERF_EN.
- Stall asserted on the cycle ack returns 0x1234 at pc 0x10: IF/ID unchanged while stalled; on the first edge after stall drops, ID_Instr=0x1234, ID_NPC=0x14; next request to 0x14.
- Redirect to 0x200 while a request to 0x40 is outstanding: 0x40 data discarded on its ack; next imem_addr=0x200; ID_Valid=0 until 0x200 data arrives.
- Redirect and stall together, skid full: skid cleared, IF/ID flushed to NOP, next fetch from redirect_pc.
- rst pulsed low mid-DROP: all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
